// File: rtl/gpio_out_multi_if.sv
// Peripheral bus bundle for gpio_out_multi: strobes, address, write data,
// acknowledges and registered read data.
interface gpio_out_multi_if #(
   parameter int ADDR_W = 5
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [7:0]        data_in;
   logic              ready_r;
   logic              ready_w;
   logic [7:0]        data_out;

   modport master (
      output read, write, address, data_in,
      input  ready_r, ready_w, data_out
   );

   modport slave (
      input  read, write, address, data_in,
      output ready_r, ready_w, data_out
   );
endinterface

// File: rtl/gpio_out_multi.sv
// Multi-channel buffered GPIO output with atomic set/clear/toggle per channel.
// Define GPIO_OUT_PULSE_EN to compile in the per-channel timed pulse engine.
module gpio_out_multi #(
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   gpio_out_multi_if.slave       bus,
   output logic [CHANNELS*8-1:0] port_out
);
   localparam int CH_W = ADDR_W - 3;

   localparam logic [2:0] SEL_DATA  = 3'd0;
   localparam logic [2:0] SEL_SET   = 3'd1;
   localparam logic [2:0] SEL_CLR   = 3'd2;
   localparam logic [2:0] SEL_TGL   = 3'd3;
`ifdef GPIO_OUT_PULSE_EN
   localparam logic [2:0] SEL_PULSE = 3'd4;
   localparam logic [2:0] SEL_PLEN  = 3'd5;
   localparam logic [2:0] SEL_STAT  = 3'd6;
`endif

   logic [2:0]          sel_s;
   logic [CH_W-1:0]     ch_s;
   logic [CHANNELS-1:0] hit_s;
   logic [CHANNELS-1:0] wr_hit_s;
   logic [7:0]          rd_ch_s [CHANNELS];
   logic [7:0]          rdata_s;

   logic [7:0]          data_q [CHANNELS];
   logic [7:0]          data_d [CHANNELS];
   logic                ready_r_q;
   logic                ready_w_q;
   logic [7:0]          data_out_q;

`ifdef GPIO_OUT_PULSE_EN
   logic [7:0]          plen_q [CHANNELS];
   logic [7:0]          plen_d [CHANNELS];
   logic [7:0]          mask_q [CHANNELS];
   logic [7:0]          mask_d [CHANNELS];
   logic [7:0]          cnt_q  [CHANNELS];
   logic [7:0]          cnt_d  [CHANNELS];
   logic [CHANNELS-1:0] active_q;
   logic [CHANNELS-1:0] active_d;
`endif

   assign sel_s = bus.address[2:0];
   assign ch_s  = bus.address[ADDR_W-1:3];

   // Channel decode; indices at or above CHANNELS never hit, so they read 0 and drop writes.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         hit_s[i]    = (ch_s == CH_W'(i));
         wr_hit_s[i] = bus.write & hit_s[i];
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         case (sel_s)
            SEL_DATA, SEL_SET, SEL_CLR, SEL_TGL: rd_ch_s[i] = data_q[i];
`ifdef GPIO_OUT_PULSE_EN
            SEL_PULSE: rd_ch_s[i] = mask_q[i];
            SEL_PLEN:  rd_ch_s[i] = plen_q[i];
            SEL_STAT:  rd_ch_s[i] = {7'b0000000, active_q[i]};
`endif
            default:   rd_ch_s[i] = 8'h00;
         endcase
      end
   end

   always_comb begin
      rdata_s = 8'h00;
      for (int i = 0; i < CHANNELS; i++) begin
         rdata_s = rdata_s | (hit_s[i] ? rd_ch_s[i] : 8'h00);
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         data_d[i] = data_q[i];
         if (wr_hit_s[i]) begin
            case (sel_s)
               SEL_DATA: data_d[i] = bus.data_in;
               SEL_SET:  data_d[i] = data_q[i] | bus.data_in;
               SEL_CLR:  data_d[i] = data_q[i] & ~bus.data_in;
               SEL_TGL:  data_d[i] = data_q[i] ^ bus.data_in;
               default:  data_d[i] = data_q[i];
            endcase
         end else begin
            data_d[i] = data_q[i];
         end
      end
   end

`ifdef GPIO_OUT_PULSE_EN
   // A PULSE write restarts the pulse and takes priority over the running countdown.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         plen_d[i]   = plen_q[i];
         mask_d[i]   = mask_q[i];
         cnt_d[i]    = cnt_q[i];
         active_d[i] = active_q[i];
         if (wr_hit_s[i] && (sel_s == SEL_PLEN)) begin
            plen_d[i] = bus.data_in;
         end else begin
            plen_d[i] = plen_q[i];
         end
         if (wr_hit_s[i] && (sel_s == SEL_PULSE) && (plen_q[i] != 8'h00)) begin
            mask_d[i]   = bus.data_in;
            cnt_d[i]    = plen_q[i];
            active_d[i] = 1'b1;
         end else if (active_q[i]) begin
            cnt_d[i] = cnt_q[i] - 8'd1;
            if (cnt_q[i] == 8'd1) begin
               active_d[i] = 1'b0;
               mask_d[i]   = 8'h00;
            end else begin
               active_d[i] = 1'b1;
               mask_d[i]   = mask_q[i];
            end
         end else begin
            cnt_d[i]    = cnt_q[i];
            active_d[i] = 1'b0;
            mask_d[i]   = mask_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            plen_q[i] <= 8'h00;
            mask_q[i] <= 8'h00;
            cnt_q[i]  <= 8'h00;
         end
         active_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            plen_q[i] <= plen_d[i];
            mask_q[i] <= mask_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         active_q <= active_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            data_q[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   // Read data is captured from pre-write state, so a simultaneous write is not visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_r_q  <= 1'b0;
         ready_w_q  <= 1'b0;
         data_out_q <= 8'h00;
      end else begin
         ready_r_q <= bus.read;
         ready_w_q <= bus.write;
         if (bus.read) begin
            data_out_q <= rdata_s;
         end else begin
            data_out_q <= data_out_q;
         end
      end
   end

   assign bus.ready_r  = ready_r_q;
   assign bus.ready_w  = ready_w_q;
   assign bus.data_out = data_out_q;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef GPIO_OUT_PULSE_EN
         port_out[8*i +: 8] = data_q[i] | (active_q[i] ? mask_q[i] : 8'h00);
`else
         port_out[8*i +: 8] = data_q[i];
`endif
      end
   end
endmodule

// File: tb/tb_gpio_out_multi.sv
// Scoreboard bench for gpio_out_multi: directed plan plus random bus traffic
// checked against a register/pulse-remaining model.
module tb_gpio_out_multi;
   localparam int CH = 4;
   localparam int AW = 6;
`ifdef GPIO_OUT_PULSE_EN
   localparam bit PULSE_EN = 1'b1;
`else
   localparam bit PULSE_EN = 1'b0;
`endif

   typedef struct packed {
      logic          rr;
      logic          rw;
      logic [CH*8-1:0] port;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [CH*8-1:0] port_out;

   gpio_out_multi_if #(.ADDR_W(AW)) bus_if ();

   gpio_out_multi #(.CHANNELS(CH), .ADDR_W(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if),
      .port_out (port_out)
   );

   always #5 clk = ~clk;

   logic [7:0] m_data [CH];
   logic [7:0] m_plen [CH];
   logic [7:0] m_mask [CH];
   int         m_rem  [CH];

   exp_t       port_q [$];
   logic [7:0] rd_q   [$];
   int         vectors     = 0;
   int         miscompares = 0;
   exp_t       e;
   logic [7:0] rexp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_read(input int ch, input int sel);
      if (ch >= CH) return 8'h00;
      case (sel)
         0, 1, 2, 3: return m_data[ch];
         4: return PULSE_EN ? m_mask[ch] : 8'h00;
         5: return PULSE_EN ? m_plen[ch] : 8'h00;
         6: return (PULSE_EN && m_rem[ch] > 0) ? 8'h01 : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   // One bus cycle: drive inputs, advance the model across the edge, queue expectations.
   task automatic cycle(input logic rst, input logic rd, input logic wr,
                        input int ch, input int sel, input logic [7:0] din);
      exp_t       x;
      logic [7:0] rv;
      reset          = rst;
      bus_if.read    = rd;
      bus_if.write   = wr;
      bus_if.address = {3'(ch), 3'(sel)};
      bus_if.data_in = din;
      rv = 8'h00;
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            m_data[c] = 8'h00; m_plen[c] = 8'h00; m_mask[c] = 8'h00; m_rem[c] = 0;
         end
         x.rr = 1'b0;
         x.rw = 1'b0;
      end else begin
         if (rd) rv = model_read(ch, sel);
         for (int c = 0; c < CH; c++) begin
            if (m_rem[c] > 0) begin
               m_rem[c]--;
               if (m_rem[c] == 0) m_mask[c] = 8'h00;
            end
         end
         if (wr && ch < CH) begin
            case (sel)
               0: m_data[ch] = din;
               1: m_data[ch] = m_data[ch] | din;
               2: m_data[ch] = m_data[ch] & ~din;
               3: m_data[ch] = m_data[ch] ^ din;
               4: if (PULSE_EN && m_plen[ch] != 8'h00) begin
                     m_mask[ch] = din;
                     m_rem[ch]  = int'(m_plen[ch]);
                  end
               5: if (PULSE_EN) m_plen[ch] = din;
               default: ;
            endcase
         end
         x.rr = rd;
         x.rw = wr;
      end
      for (int c = 0; c < CH; c++) begin
         x.port[8*c +: 8] = m_data[c] | ((m_rem[c] > 0) ? m_mask[c] : 8'h00);
      end
      @(posedge clk);
      #1;
      port_q.push_back(x);
      if (!rst && rd) rd_q.push_back(rv);
   endtask

   task automatic wr(input int ch, input int sel, input logic [7:0] d);
      cycle(1'b0, 1'b0, 1'b1, ch, sel, d);
   endtask

   task automatic rd(input int ch, input int sel);
      cycle(1'b0, 1'b1, 1'b0, ch, sel, 8'h00);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0, 0, 7, 8'h00);
   endtask

   task automatic read_all();
      for (int c = 0; c < CH; c++)
         for (int s = 0; s < 8; s++) rd(c, s);
   endtask

   // Monitor: every cycle compares acknowledges and port_out; read data on ready_r.
   always @(negedge clk) begin
      if (port_q.size() > 0) begin
         e = port_q.pop_front();
         check("ready_r", 32'(bus_if.ready_r), 32'(e.rr));
         check("ready_w", 32'(bus_if.ready_w), 32'(e.rw));
         check("port_out", port_out, e.port);
         if (bus_if.ready_r === 1'b1) begin
            check("rd_pending", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) begin
               rexp = rd_q.pop_front();
               check("data_out", 32'(bus_if.data_out), 32'(rexp));
            end
         end
      end
   end

   initial begin
      int ch, sel;
      logic [7:0] din;
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
      read_all();
      // Atomic data operations on channel 1
      wr(1, 0, 8'h0F); wr(1, 1, 8'hF0); wr(1, 2, 8'h3C); wr(1, 3, 8'hFF); idle(1);
      rd(1, 1);
      // Pulse of length 3 on channel 2 with status polling
      wr(2, 5, 8'd3); wr(2, 0, 8'h00); wr(2, 4, 8'h81);
      rd(2, 6); rd(2, 4); rd(2, 6); rd(2, 6); rd(2, 4);
      // Restart a PLEN=5 pulse one cycle in
      wr(3, 5, 8'd5); wr(3, 4, 8'h10); idle(1); wr(3, 4, 8'h02); idle(6); rd(3, 4);
      // PLEN=0 pulse is ignored
      wr(0, 5, 8'd0); wr(0, 4, 8'hAA); idle(1); rd(0, 6);
      // Simultaneous read and write
      wr(0, 0, 8'h11); cycle(1'b0, 1'b1, 1'b1, 0, 0, 8'h22); idle(1); rd(0, 0);
      // Out-of-range channels and reserved select
      wr(5, 0, 8'h55); rd(5, 0); wr(6, 4, 8'hFF); wr(7, 1, 8'hFF); rd(1, 7); wr(1, 7, 8'h12);
      // Reset mid-pulse overrides a simultaneous read and write
      wr(2, 5, 8'd8); wr(2, 4, 8'hF0); idle(2);
      cycle(1'b1, 1'b1, 1'b1, 2, 0, 8'h33);
      read_all();
      // Random traffic
      for (int n = 0; n < 700; n++) begin
         ch  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
         sel = int'($urandom_range(0, 7));
         din = (sel == 5) ? 8'($urandom_range(0, 6)) : 8'($urandom);
         cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ch, sel, din);
      end
      idle(2);
      @(negedge clk);
      #1;
      check("drain_port_q", 32'(port_q.size()), 32'd0);
      check("drain_rd_q", 32'(rd_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
